// File: rtl/decode_pkg.sv
// ----------------------------------------------------------------------------
// decode_pkg
// Shared definitions for the instruction decode stage:
//   - opcode values for the 16-bit instruction format (opcode = instr[15:12])
//   - dec_t, the decoded record stored per skid-buffer entry
//   - sext4 / sext12 helpers for immediate sign extension
// ----------------------------------------------------------------------------
package decode_pkg;

    localparam logic [3:0] OP_ALU_MAX = 4'h7;
    localparam logic [3:0] OP_ADDI    = 4'h8;
    localparam logic [3:0] OP_LOAD    = 4'h9;
    localparam logic [3:0] OP_STORE   = 4'hA;
    localparam logic [3:0] OP_BEQ     = 4'hB;
    localparam logic [3:0] OP_JMP     = 4'hC;
    localparam logic [3:0] OP_NOP     = 4'hF;

    typedef struct packed {
        logic [15:0] pc;
        logic [3:0]  rd;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [15:0] imm;
        logic [15:0] target;
        logic        reg_we;
        logic        mem_rd;
        logic        mem_wr;
        logic        branch;
        logic        jump;
        logic        illegal;
    } dec_t;

    function automatic logic [15:0] sext4(input logic [3:0] v);
        return {{12{v[3]}}, v};
    endfunction

    function automatic logic [15:0] sext12(input logic [11:0] v);
        return {{4{v[11]}}, v};
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// ----------------------------------------------------------------------------
// instr_decoder
// Purely combinational decoder: turns an instruction word and its PC into a
// dec_t record (register fields, sign-extended immediate, branch/jump target
// and control strobes).
// Ports:
//   instr  in  16  instruction word
//   pc     in  16  PC of instr
//   dec    out     decoded record
// ----------------------------------------------------------------------------
module instr_decoder
    import decode_pkg::*;
(
    input  logic [15:0] instr,
    input  logic [15:0] pc,
    output dec_t        dec
);

    logic [3:0] opcode;

    assign opcode = instr[15:12];

    always_comb begin
        dec         = '0;
        dec.pc      = pc;
        dec.rd      = instr[11:8];
        dec.rs1     = instr[7:4];
        dec.rs2     = instr[3:0];

        if (opcode <= OP_ALU_MAX) begin
            dec.reg_we = 1'b1;
        end else begin
            unique case (opcode)
                OP_ADDI: begin
                    dec.reg_we = 1'b1;
                    dec.imm    = sext4(instr[3:0]);
                end
                OP_LOAD: begin
                    dec.reg_we = 1'b1;
                    dec.mem_rd = 1'b1;
                    dec.imm    = sext4(instr[3:0]);
                end
                OP_STORE: begin
                    dec.mem_wr = 1'b1;
                    dec.imm    = sext4(instr[3:0]);
                end
                OP_BEQ: begin
                    dec.branch = 1'b1;
                    dec.imm    = sext4(instr[3:0]);
                end
                OP_JMP: begin
                    // The 12-bit jump offset overlaps all register fields,
                    // so they carry no meaning and are zeroed.
                    dec.jump = 1'b1;
                    dec.imm  = sext12(instr[11:0]);
                    dec.rd   = 4'h0;
                    dec.rs1  = 4'h0;
                    dec.rs2  = 4'h0;
                end
                OP_NOP: begin
                end
                default: begin
                    dec.illegal = 1'b1;
                end
            endcase
        end

        dec.target = pc + dec.imm;
    end

endmodule

// File: rtl/instr_decode_stage.sv
// ----------------------------------------------------------------------------
// instr_decode_stage
// Decode stage behind the instruction-memory read. Instructions are decoded
// on the write path and stored in a 2-entry skid buffer (head/tail); outputs
// come straight from the head entry's registers.
// Ports:
//   clk, reset (async, active-high)
//   in_valid/in_ready/in_instr/in_pc   upstream handshake (in_ready registered)
//   flush                              drop everything buffered and incoming
//   out_valid/out_ready                downstream handshake
//   out_pc, out_rd, out_rs1, out_rs2, out_imm, out_target   head fields
//   out_reg_we, out_mem_rd, out_mem_wr, out_branch, out_jump, out_illegal
//   issued_count                       completed output handshakes (wraps)
// ----------------------------------------------------------------------------
module instr_decode_stage
    import decode_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_instr,
    input  logic [15:0] in_pc,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_pc,
    output logic [3:0]  out_rd,
    output logic [3:0]  out_rs1,
    output logic [3:0]  out_rs2,
    output logic [15:0] out_imm,
    output logic [15:0] out_target,
    output logic        out_reg_we,
    output logic        out_mem_rd,
    output logic        out_mem_wr,
    output logic        out_branch,
    output logic        out_jump,
    output logic        out_illegal,
    output logic [15:0] issued_count
);

    dec_t       wr_dec;
    dec_t       head_q;
    dec_t       tail_q;
    logic [1:0] count_q;
    logic [1:0] count_next;
    logic       push;
    logic       pop;

    instr_decoder u_decoder (
        .instr (in_instr),
        .pc    (in_pc),
        .dec   (wr_dec)
    );

    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Occupancy after this edge; flush wins over any push or pop.
    always_comb begin
        count_next = count_q;
        if (flush) begin
            count_next = 2'd0;
        end else if (push && !pop) begin
            count_next = count_q + 2'd1;
        end else if (pop && !push) begin
            count_next = count_q - 2'd1;
        end
    end

    // Buffer storage, registered in_ready and the issue counter. The pop
    // still counts on a flush edge since the downstream consumed the head.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= 2'd0;
            in_ready     <= 1'b1;
            issued_count <= 16'd0;
        end else begin
            count_q  <= count_next;
            in_ready <= (count_next != 2'd2);
            if (pop) begin
                issued_count <= issued_count + 16'd1;
            end
            if (!flush) begin
                if (push && pop) begin
                    if (count_q == 2'd1) begin
                        head_q <= wr_dec;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= wr_dec;
                    end
                end else if (push) begin
                    if (count_q == 2'd0) begin
                        head_q <= wr_dec;
                    end else begin
                        tail_q <= wr_dec;
                    end
                end else if (pop) begin
                    head_q <= tail_q;
                end
            end
        end
    end

    // An empty buffer shows RESET_PC and all-zero fields regardless of
    // whatever stale record the head register still holds.
    always_comb begin
        out_pc      = RESET_PC;
        out_target  = RESET_PC;
        out_rd      = 4'h0;
        out_rs1     = 4'h0;
        out_rs2     = 4'h0;
        out_imm     = 16'h0;
        out_reg_we  = 1'b0;
        out_mem_rd  = 1'b0;
        out_mem_wr  = 1'b0;
        out_branch  = 1'b0;
        out_jump    = 1'b0;
        out_illegal = 1'b0;
        if (out_valid) begin
            out_pc      = head_q.pc;
            out_target  = head_q.target;
            out_rd      = head_q.rd;
            out_rs1     = head_q.rs1;
            out_rs2     = head_q.rs2;
            out_imm     = head_q.imm;
            out_reg_we  = head_q.reg_we;
            out_mem_rd  = head_q.mem_rd;
            out_mem_wr  = head_q.mem_wr;
            out_branch  = head_q.branch;
            out_jump    = head_q.jump;
            out_illegal = head_q.illegal;
        end
    end

endmodule

// File: tb/tb_instr_decode_stage.sv
// ----------------------------------------------------------------------------
// tb_instr_decode_stage
// Scoreboard bench: each accepted instruction pushes its hand-computed decoded
// record into a queue; a monitor pops and compares on every output handshake.
// ----------------------------------------------------------------------------
module tb_instr_decode_stage;

    localparam logic [15:0] RPC = 16'h1234;

    typedef struct packed {
        logic [15:0] pc;
        logic [3:0]  rd;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [15:0] imm;
        logic [15:0] target;
        logic [5:0]  strobes;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_instr = 16'h0;
    logic [15:0] in_pc = 16'h0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_pc;
    logic [3:0]  out_rd;
    logic [3:0]  out_rs1;
    logic [3:0]  out_rs2;
    logic [15:0] out_imm;
    logic [15:0] out_target;
    logic        out_reg_we;
    logic        out_mem_rd;
    logic        out_mem_wr;
    logic        out_branch;
    logic        out_jump;
    logic        out_illegal;
    logic [15:0] issued_count;

    exp_t expq[$];
    int   cmpCount = 0;
    int   errCount = 0;

    instr_decode_stage #(.RESET_PC(RPC)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_rd       (out_rd),
        .out_rs1      (out_rs1),
        .out_rs2      (out_rs2),
        .out_imm      (out_imm),
        .out_target   (out_target),
        .out_reg_we   (out_reg_we),
        .out_mem_rd   (out_mem_rd),
        .out_mem_wr   (out_mem_wr),
        .out_branch   (out_branch),
        .out_jump     (out_jump),
        .out_illegal  (out_illegal),
        .issued_count (issued_count)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [15:0] pc, input logic [3:0] rd,
                                input logic [3:0] rs1, input logic [3:0] rs2,
                                input logic [15:0] imm, input logic [15:0] tgt,
                                input logic [5:0] st);
        exp_t e;
        e.pc = pc; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
        e.imm = imm; e.target = tgt; e.strobes = st;
        return e;
    endfunction

    function automatic exp_t actual();
        return mk(out_pc, out_rd, out_rs1, out_rs2, out_imm, out_target,
                  {out_reg_we, out_mem_rd, out_mem_wr, out_branch, out_jump, out_illegal});
    endfunction

    // Monitor: a handshake completes at the next rising edge whenever
    // out_valid and out_ready are both high at the falling edge.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            exp_t a;
            exp_t e;
            a = actual();
            cmpCount++;
            if (expq.size() == 0) begin
                errCount++;
                $display("[TB] FAIL pop_unexpected: got pc=%h rd=%h rs1=%h rs2=%h imm=%h tgt=%h st=%b, expected no output",
                         a.pc, a.rd, a.rs1, a.rs2, a.imm, a.target, a.strobes);
            end else begin
                e = expq.pop_front();
                if (a !== e) begin
                    errCount++;
                    $display("[TB] FAIL pop: got pc=%h rd=%h rs1=%h rs2=%h imm=%h tgt=%h st=%b, expected pc=%h rd=%h rs1=%h rs2=%h imm=%h tgt=%h st=%b",
                             a.pc, a.rd, a.rs1, a.rs2, a.imm, a.target, a.strobes,
                             e.pc, e.rd, e.rs1, e.rs2, e.imm, e.target, e.strobes);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmpCount++;
        if (act !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic checkIdle(input string name);
        checkOutput({name, "_valid"}, {31'd0, out_valid}, 32'd0);
        checkOutput({name, "_ready"}, {31'd0, in_ready}, 32'd1);
        checkOutput({name, "_fields"}, {16'd0, actual().pc}, {16'd0, RPC});
        checkOutput({name, "_rest"},
                    {4'd0, actual().rd, actual().rs1, actual().rs2, actual().imm},
                    32'd0);
        checkOutput({name, "_tgt_st"}, {10'd0, actual().target, actual().strobes},
                    {10'd0, RPC, 6'd0});
    endtask

    task automatic applyReset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        expq.delete();
        @(posedge clk);
        #1;
    endtask

    // Presents one word and holds it until accepted; in_valid is left high
    // so consecutive calls stream back-to-back.
    task automatic applyStimulus(input logic [15:0] instr, input logic [15:0] pc, input exp_t e);
        bit done;
        done     = 0;
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                expq.push_back(e);
                done = 1;
            end
        end
        if (!done) begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (expq.size() != 0 && t < 50) begin
            @(posedge clk);
            t++;
        end
        checkOutput("drain_queue_empty", expq.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        applyReset();
        checkIdle("reset");
        checkOutput("reset_count", {16'd0, issued_count}, 32'd0);

        out_ready = 1'b1;
        applyStimulus(16'h8A35, 16'h0004, mk(16'h0004, 4'hA, 4'h3, 4'h5, 16'h0005, 16'h0009, 6'b100000));
        in_valid = 1'b0;
        checkOutput("latency_valid", {31'd0, out_valid}, 32'd1);
        drain();

        applyStimulus(16'hCFFE, 16'h0010, mk(16'h0010, 4'h0, 4'h0, 4'h0, 16'hFFFE, 16'h000E, 6'b000010));
        applyStimulus(16'hB01F, 16'hFFFF, mk(16'hFFFF, 4'h0, 4'h1, 4'hF, 16'hFFFF, 16'hFFFE, 6'b000100));
        in_valid = 1'b0;
        drain();

        // Stall: two absorbed, third held off until the head drains.
        applyReset();
        applyStimulus(16'h9123, 16'h0020, mk(16'h0020, 4'h1, 4'h2, 4'h3, 16'h0003, 16'h0023, 6'b110000));
        checkOutput("one_entry_ready", {31'd0, in_ready}, 32'd1);
        applyStimulus(16'hA456, 16'h0021, mk(16'h0021, 4'h4, 4'h5, 4'h6, 16'h0006, 16'h0027, 6'b001000));
        checkOutput("full_ready_low", {31'd0, in_ready}, 32'd0);
        in_instr = 16'h0789;
        in_pc    = 16'h0022;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("full_still_low", {31'd0, in_ready}, 32'd0);
        checkOutput("head_stable", {16'd0, out_pc}, 32'h0020);
        out_ready = 1'b1;
        applyStimulus(16'h0789, 16'h0022, mk(16'h0022, 4'h7, 4'h8, 4'h9, 16'h0000, 16'h0022, 6'b100000));
        in_valid = 1'b0;
        drain();
        checkOutput("count_after_three", {16'd0, issued_count}, 32'd3);

        applyStimulus(16'hD000, 16'h0030, mk(16'h0030, 4'h0, 4'h0, 4'h0, 16'h0000, 16'h0030, 6'b000001));
        in_valid = 1'b0;
        drain();
        checkOutput("count_illegal", {16'd0, issued_count}, 32'd4);

        // Flush with a full buffer and an incoming word.
        out_ready = 1'b0;
        applyStimulus(16'h8222, 16'h0040, mk(16'h0040, 4'h2, 4'h2, 4'h2, 16'h0002, 16'h0042, 6'b100000));
        applyStimulus(16'h8333, 16'h0041, mk(16'h0041, 4'h3, 4'h3, 4'h3, 16'h0003, 16'h0044, 6'b100000));
        in_instr = 16'h8111;
        in_pc    = 16'h0042;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        expq.delete();
        checkIdle("flush_full");
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("flush_no_pop", {16'd0, issued_count}, 32'd4);

        // Flush with one entry while it is popped and a push is offered.
        out_ready = 1'b0;
        applyStimulus(16'h8444, 16'h0050, mk(16'h0050, 4'h4, 4'h4, 4'h4, 16'h0004, 16'h0054, 6'b100000));
        in_instr  = 16'h8111;
        in_pc     = 16'h0051;
        flush     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        checkOutput("flush_pop_counted", {16'd0, issued_count}, 32'd5);
        checkOutput("flush_push_dropped", {31'd0, out_valid}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("flush_queue", expq.size(), 32'd0);

        // Asynchronous reset between edges with two entries buffered.
        out_ready = 1'b0;
        applyStimulus(16'h8555, 16'h0060, mk(16'h0060, 4'h5, 4'h5, 4'h5, 16'h0005, 16'h0065, 6'b100000));
        applyStimulus(16'h8666, 16'h0061, mk(16'h0061, 4'h6, 4'h6, 4'h6, 16'h0006, 16'h0067, 6'b100000));
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checkIdle("async_reset");
        checkOutput("async_reset_count", {16'd0, issued_count}, 32'd0);
        expq.delete();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Counter wrap: 65535 pops, then one more.
        out_ready = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            applyStimulus(16'hF000, 16'(i), mk(16'(i), 4'h0, 4'h0, 4'h0, 16'h0000, 16'(i), 6'b000000));
        end
        in_valid = 1'b0;
        drain();
        checkOutput("count_ffff", {16'd0, issued_count}, 32'h0000FFFF);
        applyStimulus(16'hF000, 16'hFFFF, mk(16'hFFFF, 4'h0, 4'h0, 4'h0, 16'h0000, 16'hFFFF, 6'b000000));
        in_valid = 1'b0;
        drain();
        checkOutput("count_wrap", {16'd0, issued_count}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
        $finish;
    end

endmodule
